// File: rtl/bus_master_dma.sv
// Single-channel bus-master DMA: copies size words from src_addr to dst_addr.
// Latency: 3 cycles per word (read, capture, write) plus one request cycle and one done cycle.
// Backpressure: stalls in REQ until M_grant; a lost grant returns to REQ and retries the current word.
//
// Ports:
//   clk, reset             - system clock, synchronous active-high reset
//   start                  - one-cycle pulse, accepted only when idle
//   src_addr/dst_addr/size - copy parameters, latched on an accepted start
//   M_grant, M_din         - arbiter grant and slave read data (valid the cycle after a read address)
//   M_req, M_wr, M_addr, M_dout - bus request, write strobe, address and write data
//   busy, done             - transfer in progress, one-cycle completion pulse
module bus_master_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  src_addr,
    input  logic [7:0]  dst_addr,
    input  logic [4:0]  size,
    input  logic        M_grant,
    input  logic [31:0] M_din,
    output logic        M_req,
    output logic        M_wr,
    output logic [7:0]  M_addr,
    output logic [31:0] M_dout,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        RD     = 3'd2,
        RD_CAP = 3'd3,
        WR     = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_src, w_src_nxt;
    logic [7:0]  r_dst, w_dst_nxt;
    logic [4:0]  r_size, w_size_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_data, w_data_nxt;

    logic [7:0]  w_rd_addr;
    logic [7:0]  w_wr_addr;
    logic        w_last;

    // 8-bit adds wrap naturally at 8'hFF.
    assign w_rd_addr = r_src + {3'b000, r_cnt};
    assign w_wr_addr = r_dst + {3'b000, r_cnt};
    // size is never 0 outside IDLE/DONE, so size-1 does not underflow here.
    assign w_last    = (r_cnt == (r_size - 5'd1));

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_size_nxt  = r_size;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        M_req       = 1'b0;
        M_wr        = 1'b0;
        M_addr      = 8'h00;
        M_dout      = 32'h0;
        busy        = 1'b1;
        done        = 1'b0;

        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_src_nxt   = src_addr;
                    w_dst_nxt   = dst_addr;
                    w_size_nxt  = size;
                    w_cnt_nxt   = 5'd0;
                    // Zero-length copy never touches the bus.
                    w_state_nxt = (size == 5'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                M_req = 1'b1;
                if (M_grant) w_state_nxt = RD;
            end
            RD: begin
                M_req       = 1'b1;
                M_addr      = w_rd_addr;
                w_state_nxt = M_grant ? RD_CAP : REQ;
            end
            RD_CAP: begin
                M_req = 1'b1;
                if (M_grant) begin
                    w_data_nxt  = M_din;
                    w_state_nxt = WR;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            WR: begin
                M_req  = 1'b1;
                M_addr = w_wr_addr;
                M_dout = r_data;
                if (M_grant) begin
                    M_wr = 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt   = r_cnt + 5'd1;
                        w_state_nxt = RD;
                    end
                end else begin
                    // Strobe withheld; the same word is re-read after re-arbitration.
                    w_state_nxt = REQ;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_src   <= 8'h00;
            r_dst   <= 8'h00;
            r_size  <= 5'd0;
            r_cnt   <= 5'd0;
            r_data  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_size  <= w_size_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
        end
    end

endmodule

// File: tb/tb_bus_master_dma.sv
module tb_bus_master_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;
    logic [4:0]  size;
    logic        M_grant;
    logic [31:0] M_din;
    logic        M_req;
    logic        M_wr;
    logic [7:0]  M_addr;
    logic [31:0] M_dout;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];

    bus_master_dma dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .size     (size),
        .M_grant  (M_grant),
        .M_din    (M_din),
        .M_req    (M_req),
        .M_wr     (M_wr),
        .M_addr   (M_addr),
        .M_dout   (M_dout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: registered read, data = A0 + address, valid the cycle after the address.
    always @(posedge clk) M_din <= 32'hA0 + {24'h0, M_addr};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe and every done pulse must match the next expectation.
    always @(negedge clk) begin
        if (M_wr === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", M_addr, M_dout);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("write", {24'h0, M_addr, M_dout}, {24'h0, e.a, e.d});
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                int e;
                e = done_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start; queue the first k_wr expected writes and, if lat>0, a done lat cycles later.
    task automatic do_start(input logic [7:0] s, input logic [7:0] d, input logic [4:0] n,
                            input int k_wr, input int lat);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        size     = n;
        for (int i = 0; i < k_wr; i++) begin
            logic [7:0] ra;
            wr_t        w;
            ra  = s + i[7:0];
            w.a = d + i[7:0];
            w.d = 32'hA0 + {24'h0, ra};
            wr_q.push_back(w);
        end
        if (lat > 0) done_q.push_back(cyc + lat);
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int g = 0;
        while ((wr_q.size() != 0 || done_q.size() != 0) && g < 100) begin
            tick();
            g++;
        end
        check(name, 64'(wr_q.size() + done_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {56'h0, M_req, M_wr, busy, done, 4'h0}, 64'h0);
        check({name, "_bus"}, {24'h0, M_addr, M_dout}, 64'h0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = 8'h00;
        dst_addr = 8'h00;
        size     = 5'd0;
        M_grant  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_idle_outputs("reset_state");

        // Basic copy: 3 words 10..12 -> 40..42, done 11 cycles after start.
        do_start(8'h10, 8'h40, 5'd3, 3, 11);
        check("basic_busy", 64'(busy), 64'd1);
        check("basic_req", 64'(M_req), 64'd1);
        drain("basic_drain");
        check("basic_req_after", 64'(M_req), 64'd0);
        check("basic_busy_after", 64'(busy), 64'd0);
        tick();

        // size=0: done the next cycle, no bus request.
        do_start(8'h33, 8'h44, 5'd0, 0, 1);
        check("size0_req", 64'(M_req), 64'd0);
        check("size0_busy", 64'(busy), 64'd1);
        tick();
        check("size0_req_after", 64'(M_req), 64'd0);
        drain("size0_drain");
        tick();

        // Grant lost in word 1's WR (cycle c+7): retry costs 4 extra cycles -> done at c+15.
        do_start(8'h20, 8'h60, 5'd3, 3, 15);
        repeat (6) tick();
        M_grant = 1'b0;
        #1;
        check("grant_loss_wr", 64'(M_wr), 64'd0);
        tick();
        M_grant = 1'b1;
        check("grant_loss_rereq", 64'(M_req), 64'd1);
        drain("grant_drain");
        tick();

        // Address wrap: reads FE/FF/00, writes FF/00/01.
        do_start(8'hFE, 8'hFF, 5'd3, 3, 11);
        drain("wrap_drain");
        tick();

        // Reset in RD of word 2 (cycle c+8): only words 0 and 1 written, no done.
        do_start(8'h50, 8'h80, 5'd3, 2, 0);
        repeat (7) tick();
        check("rst_rd_addr", 64'(M_addr), 64'h52);
        check("rst_rd_wr", 64'(M_wr), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("midreset");
        repeat (5) tick();
        check("midreset_queue", 64'(wr_q.size()), 64'd0);
        do_start(8'h05, 8'h90, 5'd1, 1, 5);
        drain("after_reset_drain");
        tick();

        // Second start while busy is ignored; original 2-word copy completes in 8 cycles.
        do_start(8'h30, 8'h70, 5'd2, 2, 8);
        tick();
        start    = 1'b1;
        src_addr = 8'h99;
        dst_addr = 8'hAA;
        size     = 5'd5;
        tick();
        start = 1'b0;
        check("busy_start_busy", 64'(busy), 64'd1);
        drain("busy_start_drain");
        repeat (6) tick();
        check("busy_start_idle", 64'(M_req), 64'd0);
        check("final_queues", 64'(wr_q.size() + done_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
